// File: rtl/uart_tx_serializer_pkg.sv
// Shared UART definitions: FSM state encoding and FIFO pointer width rule.
// Used by the TX serializer, the RX side and the FIFO writer.
package uart_tx_serializer_pkg;

  // Transmit FSM states, in frame order
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LOAD   = 3'd2,
    S_START  = 3'd3,
    S_DATA   = 3'd4,
    S_PARITY = 3'd5,
    S_STOP   = 3'd6
  } tx_state_t;

  // Pointer width wide enough to hold 0..depth
  function automatic int addr_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/uart_tx_serializer_if.sv
// FIFO read-side bundle between the TX serializer (reader) and the FIFO storage.
// master = serializer: owns the read strobe, read pointer and empty flag.
// slave  = FIFO/writer: provides the write pointer and registered read data.
interface uart_tx_serializer_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8
);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [DATA_WIDTH-1:0] rd_buf;
  logic                  rden;
  logic                  empty;

  modport master (
    input  wr_ptr,
    input  rd_buf,
    output rd_ptr,
    output rden,
    output empty
  );

  modport slave (
    output wr_ptr,
    output rd_buf,
    input  rd_ptr,
    input  rden,
    input  empty
  );

endinterface

// File: rtl/uart_tx_serializer_baud_counter.sv
// Bit-time counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the
// last cycle of each bit. A synchronous clear parks it at 0 between frames.
module uart_baud_counter #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic clr_i,
  input  logic en_i,
  output logic bit_tick_o
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_count;

  assign bit_tick_o = en_i && (r_count == CNT_LAST);

  // Free-running modulo counter, held at zero while cleared
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_count <= '0;
    end else if (clr_i) begin
      r_count <= '0;
    end else if (en_i) begin
      if (r_count == CNT_LAST) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: reads bytes from the TX FIFO (single clock reader)
// and shifts each out as start / data LSB-first / optional parity / stop bits.
module uart_tx_serializer
  import uart_tx_serializer_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int FIFO_DEPTH   = 50,
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                tx_en_i,
  input  logic                parity_en_i,
  input  logic                parity_odd_i,
  uart_tx_serializer_if.master fifo_if,
  output logic                tx_o,
  output logic                busy_o,
  output logic                tx_done_o
);

  localparam int ADDR_WIDTH = addr_width(FIFO_DEPTH);
  localparam int BIT_CNT_W  = $clog2(DATA_WIDTH + 1);
  localparam logic [ADDR_WIDTH-1:0] PTR_LAST  = ADDR_WIDTH'(FIFO_DEPTH - 1);
  localparam logic [BIT_CNT_W-1:0]  DATA_LAST = BIT_CNT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_CNT_W-1:0]  STOP_LAST = BIT_CNT_W'(STOP_BITS - 1);

  tx_state_t             r_state;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic                  r_rden;
  logic                  r_tx;
  logic                  r_busy;
  logic                  r_tx_done;
  logic [DATA_WIDTH-1:0] r_shreg;
  logic [BIT_CNT_W-1:0]  r_bit_cnt;
  logic                  r_par_en;
  logic                  r_par_bit;

  logic                  w_empty;
  logic                  w_bit_phase;
  logic                  w_bit_tick;
  logic                  w_start_next;
  logic [ADDR_WIDTH-1:0] w_rd_ptr_next;

  assign w_empty       = (r_rd_ptr == fifo_if.wr_ptr);
  assign w_start_next  = tx_en_i && !w_empty;
  assign w_rd_ptr_next = (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
  assign w_bit_phase   = (r_state == S_START) || (r_state == S_DATA) ||
                         (r_state == S_PARITY) || (r_state == S_STOP);

  assign fifo_if.rden   = r_rden;
  assign fifo_if.rd_ptr = r_rd_ptr;
  assign fifo_if.empty  = w_empty;
  assign tx_o           = r_tx;
  assign busy_o         = r_busy;
  assign tx_done_o      = r_tx_done;

  // Baud timing runs only while a bit is on the line; FETCH/LOAD keep it at 0
  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .clr_i      (!w_bit_phase),
    .en_i       (w_bit_phase),
    .bit_tick_o (w_bit_tick)
  );

  // Frame sequencer with registered line, strobe and status outputs
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_state   <= S_IDLE;
      r_rd_ptr  <= '0;
      r_rden    <= 1'b0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_tx_done <= 1'b0;
      r_shreg   <= '0;
      r_bit_cnt <= '0;
      r_par_en  <= 1'b0;
      r_par_bit <= 1'b0;
    end else begin
      r_rden    <= 1'b0;
      r_tx_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start_next) begin
            r_state <= S_FETCH;
            r_rden  <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        S_FETCH: begin
          // FIFO samples rden with the current pointer on this edge
          r_rd_ptr <= w_rd_ptr_next;
          r_state  <= S_LOAD;
        end
        S_LOAD: begin
          // Parity settings are frozen here so mid-frame changes cannot corrupt the frame
          r_shreg   <= fifo_if.rd_buf;
          r_par_en  <= parity_en_i;
          r_par_bit <= (^fifo_if.rd_buf) ^ parity_odd_i;
          r_bit_cnt <= '0;
          r_tx      <= 1'b0;
          r_state   <= S_START;
        end
        S_START: begin
          if (w_bit_tick) begin
            r_tx    <= r_shreg[0];
            r_shreg <= r_shreg >> 1;
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_bit_tick) begin
            if (r_bit_cnt == DATA_LAST) begin
              r_bit_cnt <= '0;
              if (r_par_en) begin
                r_tx    <= r_par_bit;
                r_state <= S_PARITY;
              end else begin
                r_tx    <= 1'b1;
                r_state <= S_STOP;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
              r_tx      <= r_shreg[0];
              r_shreg   <= r_shreg >> 1;
            end
          end
        end
        S_PARITY: begin
          if (w_bit_tick) begin
            r_tx    <= 1'b1;
            r_state <= S_STOP;
          end
        end
        S_STOP: begin
          if (w_bit_tick) begin
            if (r_bit_cnt == STOP_LAST) begin
              r_bit_cnt <= '0;
              r_tx_done <= 1'b1;
              if (w_start_next) begin
                r_state <= S_FETCH;
                r_rden  <= 1'b1;
              end else begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: a small FIFO model feeds bytes,
// and each frame is compared cycle by cycle against a bit list built from the
// UART framing rules.
module tb_uart_tx_serializer;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int CLKS  = 4;
  localparam int STOP  = 1;
  localparam int AW    = 3;

  logic clk = 1'b0;
  logic rstn;
  logic tx_en;
  logic par_en;
  logic par_odd;
  logic tx;
  logic busy;
  logic tx_done;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] mem [DEPTH];

  uart_tx_serializer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) fifo_if ();

  uart_tx_serializer #(
    .DATA_WIDTH  (DW),
    .FIFO_DEPTH  (DEPTH),
    .CLKS_PER_BIT(CLKS),
    .STOP_BITS   (STOP)
  ) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .tx_en_i     (tx_en),
    .parity_en_i (par_en),
    .parity_odd_i(par_odd),
    .fifo_if     (fifo_if.master),
    .tx_o        (tx),
    .busy_o      (busy),
    .tx_done_o   (tx_done)
  );

  initial forever #5 clk = ~clk;

  // FIFO storage model: registered read, data valid one cycle after rden
  always @(posedge clk) begin
    if (fifo_if.rden) fifo_if.rd_buf <= mem[fifo_if.rd_ptr];
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  task automatic fifo_write(input logic [DW-1:0] d);
    mem[fifo_if.wr_ptr] = d;
    fifo_if.wr_ptr = (fifo_if.wr_ptr == AW'(DEPTH - 1)) ? '0 : fifo_if.wr_ptr + 1'b1;
    $display("write data=%02h wr_ptr=%0d", d, fifo_if.wr_ptr);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rstn = 1'b0;
    tx_en = 1'b0;
    par_en = 1'b0;
    par_odd = 1'b0;
    fifo_if.wr_ptr = '0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  // Waits for the start bit, then checks every cycle of the frame and the done pulse.
  task automatic expect_frame(input logic [DW-1:0] d, input bit pen, input bit podd,
                              input bit more, input logic [AW-1:0] exp_rd,
                              input int drop_at, output int waited);
    bit q[$];
    int ones;
    bit pbit;
    int k;
    ones = $countones(d);
    pbit = podd ? ((ones % 2) == 0) : ((ones % 2) == 1);
    q.push_back(1'b0);
    for (int i = 0; i < DW; i++) q.push_back(d[i]);
    if (pen) q.push_back(pbit);
    for (int s = 0; s < STOP; s++) q.push_back(1'b1);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (tx !== 1'b0 && waited < 200);
    checks++;
    if (tx !== 1'b0) begin
      failures++;
      $display("FAIL start_timeout tx=%b after %0d cycles, required start bit 0", tx, waited);
      return;
    end
    k = 0;
    foreach (q[b]) begin
      for (int c = 0; c < CLKS; c++) begin
        if (k != 0) @(negedge clk);
        if (k == drop_at) tx_en = 1'b0;
        checks++;
        if (tx !== q[b]) begin
          failures++;
          $display("FAIL frame_bit data=%02h bit=%0d cyc=%0d tx=%b required %b", d, b, c, tx, q[b]);
        end
        checks++;
        if ({tx_done, fifo_if.rden, busy} !== 3'b001) begin
          failures++;
          $display("FAIL frame_status data=%02h cycle=%0d done,rden,busy=%b required 001",
                   d, k, {tx_done, fifo_if.rden, busy});
        end
        k++;
      end
    end
    @(negedge clk);
    checks++;
    if ({tx_done, tx, busy, fifo_if.rden, fifo_if.rd_ptr} !== {1'b1, 1'b1, more, more, exp_rd}) begin
      failures++;
      $display("FAIL frame_end data=%02h done=%b tx=%b busy=%b rden=%b rd_ptr=%0d required 1 1 %b %b %0d",
               d, tx_done, tx, busy, fifo_if.rden, fifo_if.rd_ptr, more, more, exp_rd);
    end
    $display("frame data=%02h pen=%0d odd=%0d bits=%0d gap=%0d rd_ptr=%0d",
             d, pen, podd, q.size(), waited, fifo_if.rd_ptr);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    tx_en = 1'b1;
    par_en = 1'b0;
    par_odd = 1'b0;
    fifo_if.wr_ptr = '0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      checks++;
      if ({tx, busy, fifo_if.empty, fifo_if.rden, fifo_if.rd_ptr} !== {1'b1, 1'b0, 1'b1, 1'b0, 3'd0}) begin
        failures++;
        $display("FAIL reset_idle cycle=%0d tx,busy,empty,rden=%b rd_ptr=%0d required 1010 0",
                 i, {tx, busy, fifo_if.empty, fifo_if.rden}, fifo_if.rd_ptr);
      end
    end
    $display("reset idle checked 100 cycles");
  endtask

  task automatic test_single_byte();
    int w;
    apply_reset();
    tx_en = 1'b1;
    @(negedge clk);
    fifo_write(8'h55);
    @(negedge clk);
    checks++;
    if ({fifo_if.rden, fifo_if.rd_ptr} !== {1'b1, 3'd0}) begin
      failures++;
      $display("FAIL fetch_strobe rden=%b rd_ptr=%0d required 1 0", fifo_if.rden, fifo_if.rd_ptr);
    end
    @(negedge clk);
    checks++;
    if ({fifo_if.rden, fifo_if.rd_ptr} !== {1'b0, 3'd1}) begin
      failures++;
      $display("FAIL load_ptr rden=%b rd_ptr=%0d required 0 1", fifo_if.rden, fifo_if.rd_ptr);
    end
    expect_frame(8'h55, 1'b0, 1'b0, 1'b0, 3'd1, -1, w);
    checks++;
    if (w !== 1) begin
      failures++;
      $display("FAIL start_latency waited=%0d required 1", w);
    end
    @(negedge clk);
    checks++;
    if (tx_done !== 1'b0) begin
      failures++;
      $display("FAIL done_single_pulse tx_done=%b required 0", tx_done);
    end
  endtask

  task automatic test_parity();
    int w;
    logic [AW-1:0] exp_rd;
    apply_reset();
    tx_en = 1'b1;
    exp_rd = '0;
    for (int odd = 0; odd < 2; odd++) begin
      par_en = 1'b1;
      par_odd = odd[0];
      @(negedge clk);
      fifo_write(8'h07);
      exp_rd = exp_rd + 1'b1;
      expect_frame(8'h07, 1'b1, odd[0], 1'b0, exp_rd, -1, w);
      checks++;
      if (w !== 3) begin
        failures++;
        $display("FAIL parity_latency odd=%0d waited=%0d required 3", odd, w);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] b [5];
    logic [AW-1:0] rd_seq [5];
    int w;
    rd_seq[0] = 3'd1; rd_seq[1] = 3'd2; rd_seq[2] = 3'd3; rd_seq[3] = 3'd0; rd_seq[4] = 3'd1;
    for (int i = 0; i < 5; i++) b[i] = DW'($urandom);
    apply_reset();
    tx_en = 1'b1;
    @(negedge clk);
    fifo_write(b[0]);
    @(negedge clk);
    fifo_write(b[1]);
    @(negedge clk);
    fifo_write(b[2]);
    fifo_write(b[3]);
    for (int i = 0; i < 5; i++) begin
      expect_frame(b[i], 1'b0, 1'b0, (i < 4), rd_seq[i], -1, w);
      checks++;
      if (w !== ((i == 0) ? 1 : 2)) begin
        failures++;
        $display("FAIL b2b_gap frame=%0d waited=%0d required %0d", i, w, (i == 0) ? 1 : 2);
      end
      if (i == 1) fifo_write(b[4]);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [DW-1:0] d;
    int n;
    d = DW'($urandom);
    apply_reset();
    tx_en = 1'b1;
    @(negedge clk);
    fifo_write(d);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tx !== 1'b0 && n < 50);
    checks++;
    if (tx !== 1'b0) begin
      failures++;
      $display("FAIL midrst_start tx=%b required 0", tx);
    end
    repeat (4 * CLKS + 1) @(negedge clk);
    checks++;
    if (tx !== d[3]) begin
      failures++;
      $display("FAIL midrst_bit3 tx=%b required %b", tx, d[3]);
    end
    rstn = 1'b0;
    fifo_if.wr_ptr = '0;
    @(negedge clk);
    checks++;
    if ({tx, busy, tx_done, fifo_if.rden, fifo_if.rd_ptr} !== {1'b1, 1'b0, 1'b0, 1'b0, 3'd0}) begin
      failures++;
      $display("FAIL midrst_state tx,busy,done,rden=%b rd_ptr=%0d required 1000 0",
               {tx, busy, tx_done, fifo_if.rden}, fifo_if.rd_ptr);
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      checks++;
      if ({tx, busy, tx_done} !== 3'b100) begin
        failures++;
        $display("FAIL midrst_quiet cycle=%0d tx,busy,done=%b required 100", i, {tx, busy, tx_done});
      end
    end
    $display("reset mid-frame data=%02h line released high", d);
  endtask

  task automatic test_tx_en_drop();
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    int w;
    d0 = DW'($urandom);
    d1 = DW'($urandom);
    apply_reset();
    @(negedge clk);
    fifo_write(d0);
    fifo_write(d1);
    tx_en = 1'b1;
    expect_frame(d0, 1'b0, 1'b0, 1'b0, 3'd1, 5, w);
    checks++;
    if (w !== 3) begin
      failures++;
      $display("FAIL en_drop_latency waited=%0d required 3", w);
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      checks++;
      if ({tx, busy, fifo_if.rden, fifo_if.empty} !== 4'b1000) begin
        failures++;
        $display("FAIL en_drop_hold cycle=%0d tx,busy,rden,empty=%b required 1000",
                 i, {tx, busy, fifo_if.rden, fifo_if.empty});
      end
    end
    tx_en = 1'b1;
    expect_frame(d1, 1'b0, 1'b0, 1'b0, 3'd2, -1, w);
    checks++;
    if (w !== 3) begin
      failures++;
      $display("FAIL en_resume_latency waited=%0d required 3", w);
    end
  endtask

  task automatic test_random_frames();
    logic [DW-1:0] d;
    logic [AW-1:0] exp_rd;
    bit pen;
    bit podd;
    int w;
    apply_reset();
    tx_en = 1'b1;
    exp_rd = '0;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      d = DW'($urandom);
      pen = 1'($urandom_range(0, 1));
      podd = 1'($urandom_range(0, 1));
      par_en = pen;
      par_odd = podd;
      fifo_write(d);
      exp_rd = (exp_rd == AW'(DEPTH - 1)) ? '0 : exp_rd + 1'b1;
      expect_frame(d, pen, podd, 1'b0, exp_rd, -1, w);
      checks++;
      if (w !== 3) begin
        failures++;
        $display("FAIL random_latency frame=%0d waited=%0d required 3", i, w);
      end
    end
  endtask

  initial begin
    rstn = 1'b0;
    tx_en = 1'b0;
    par_en = 1'b0;
    par_odd = 1'b0;
    fifo_if.wr_ptr = '0;
    test_reset();
    test_single_byte();
    test_parity();
    test_back_to_back();
    test_reset_mid_frame();
    test_tx_en_drop();
    test_random_frames();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
